// File: rtl/axis_frame_gate.sv
// axis_frame_gate: triggered packetizer for the ADC sample stream.
// Idle: every upstream beat is accepted and dropped so the source never stalls.
// A rising edge on trg_flag forwards exactly cfg_data beats through a
// registered output stage and marks the final beat with m_axis_tlast.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | discard input, wait for a trigger edge with nonzero length
// ST_ACTIVE | forward input beats into the output register, count them
// ST_DRAIN  | last beat is loaded; discard input until it is taken
module axis_frame_gate #(
   parameter int AXIS_TDATA_WIDTH = 16,
   parameter int CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [CNTR_WIDTH-1:0]       cfg_data,
   input  logic                        trg_flag,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready,
   output logic                        sts_busy,
   output logic [CNTR_WIDTH-1:0]       sts_packets,
   output logic [15:0]                 sts_missed
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);
   localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = '0;

   state_t                        r_state;
   state_t                        w_state_nxt;

   logic                          r_trg_q;
   logic [CNTR_WIDTH-1:0]         r_len;
   logic [CNTR_WIDTH-1:0]         r_cnt;
   logic [CNTR_WIDTH-1:0]         r_packets;
   logic [15:0]                   r_missed;
   logic [AXIS_TDATA_WIDTH-1:0]   r_tdata;
   logic                          r_tvalid;
   logic                          r_tlast;

   logic                          w_trg_edge;
   logic                          w_start;
   logic                          w_missed;
   logic                          w_s_ready;
   logic                          w_in_hs;
   logic                          w_load;
   logic                          w_last_beat;
   logic                          w_out_hs;
   logic                          w_frame_done;

   // r_trg_q resets high so a trigger already asserted at reset release
   // does not look like a fresh edge.
   assign w_trg_edge   = trg_flag & ~r_trg_q;
   assign w_start      = (r_state == ST_IDLE) & w_trg_edge & (cfg_data != CNT_ZERO);
   assign w_missed     = (r_state != ST_IDLE) & w_trg_edge;

   // Only ACTIVE can apply backpressure; IDLE and DRAIN always swallow input.
   assign w_s_ready    = (r_state == ST_ACTIVE) ? (~r_tvalid | m_axis_tready) : 1'b1;
   assign w_in_hs      = s_axis_tvalid & w_s_ready;
   assign w_load       = (r_state == ST_ACTIVE) & w_in_hs;
   assign w_last_beat  = (r_cnt == (r_len - CNT_ONE));

   assign w_out_hs     = r_tvalid & m_axis_tready;
   assign w_frame_done = (r_state == ST_DRAIN) & w_out_hs & r_tlast;

   // State register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (w_load && w_last_beat) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_frame_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Trigger history for edge detection.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_trg_q <= 1'b1;
      end else begin
         r_trg_q <= trg_flag;
      end
   end

   // Frame length is captured at the trigger and held for the whole frame;
   // the beat counter restarts at each accepted trigger.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_len <= '0;
         r_cnt <= '0;
      end else if (w_start) begin
         r_len <= cfg_data;
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // Output register: load on an input handshake in ACTIVE, otherwise retire
   // the current beat once the sink takes it. Data is held while stalled.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else if (w_load) begin
         r_tdata  <= s_axis_tdata;
         r_tvalid <= 1'b1;
         r_tlast  <= w_last_beat;
      end else if (m_axis_tready) begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end
   end

   // Status counters; both wrap naturally.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_packets <= '0;
         r_missed  <= '0;
      end else begin
         if (w_frame_done) begin
            r_packets <= r_packets + CNT_ONE;
         end
         if (w_missed) begin
            r_missed <= r_missed + 16'd1;
         end
      end
   end

   assign s_axis_tready = w_s_ready;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign sts_busy      = (r_state != ST_IDLE);
   assign sts_packets   = r_packets;
   assign sts_missed    = r_missed;

endmodule

// File: tb/tb_axis_frame_gate.sv
// Testbench for axis_frame_gate: a table of per-cycle vectors followed by
// hand-written multi-cycle sequences driven from a free-running ramp source.
module tb_axis_frame_gate;

   localparam int DW = 16;
   localparam int CW = 32;

   logic          aclk = 1'b0;
   logic          areset;
   logic [CW-1:0] cfg_data;
   logic          trg_flag;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;
   logic          sts_busy;
   logic [CW-1:0] sts_packets;
   logic [15:0]   sts_missed;

   always #5 aclk = ~aclk;

   axis_frame_gate #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_data      (cfg_data),
      .trg_flag      (trg_flag),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .sts_busy      (sts_busy),
      .sts_packets   (sts_packets),
      .sts_missed    (sts_missed)
   );

   typedef struct {
      logic        rst, trg, vld;
      logic [15:0] dat;
      logic        rdy;
      logic [31:0] cfg;
      logic        chk;
      logic        srdy, mv, ml;
      logic [15:0] md;
      logic        chkd, busy;
      logic [31:0] pk;
      logic [15:0] ms;
   } vec_t;

   localparam int NV = 32;
   vec_t vecs [NV];

   int n_tests = 0;
   int n_fail  = 0;

   logic          g_rst = 1'b0;
   logic          g_trg = 1'b0;
   logic          g_rdy = 1'b1;
   logic [CW-1:0] g_cfg = '0;
   int            src   = 1000;

   function automatic vec_t mk(input int rst, trg, vld, dat, rdy, cfg, chk,
                               srdy, mv, ml, md, chkd, busy, pk, ms);
      vec_t v;
      v.rst = rst[0]; v.trg = trg[0]; v.vld = vld[0]; v.dat = dat[15:0];
      v.rdy = rdy[0]; v.cfg = cfg; v.chk = chk[0];
      v.srdy = srdy[0]; v.mv = mv[0]; v.ml = ml[0]; v.md = md[15:0];
      v.chkd = chkd[0]; v.busy = busy[0]; v.pk = pk; v.ms = ms[15:0];
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock of the ramp source: inputs change on the falling edge,
   // outputs are observed 1 ns later, the handshake happens at the next rise.
   task automatic cycle();
      @(negedge aclk);
      areset        = g_rst;
      trg_flag      = g_trg;
      cfg_data      = g_cfg;
      m_axis_tready = g_rdy;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src[15:0];
      #1;
      if (s_axis_tready) src++;
   endtask

   task automatic pulse(input int cfg);
      g_cfg = cfg;
      g_trg = 1'b0;
      cycle();
      g_trg = 1'b1;
      cycle();
      g_trg = 1'b0;
   endtask

   task automatic collect(input bit toggle, input int cfg_mid, input int budget,
                          output int nb, output int firstv, output int seq_err,
                          output int stall_err, output int bp_err, output int got_last);
      logic [15:0] prev_d;
      logic [15:0] prev_hs;
      logic        prev_stall;
      prev_d = '0; prev_hs = '0; prev_stall = 1'b0;
      nb = 0; firstv = -1; seq_err = 0; stall_err = 0; bp_err = 0; got_last = 0;
      g_rdy = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (toggle) g_rdy = ~g_rdy;
         cycle();
         if (prev_stall && (m_axis_tdata !== prev_d)) stall_err++;
         if (m_axis_tvalid && !g_rdy && !m_axis_tlast && s_axis_tready) bp_err++;
         prev_stall = m_axis_tvalid && !g_rdy;
         prev_d     = m_axis_tdata;
         if (m_axis_tvalid && g_rdy) begin
            if (nb == 0) firstv = int'(m_axis_tdata);
            else if (m_axis_tdata !== prev_hs + 16'd1) seq_err++;
            prev_hs = m_axis_tdata;
            nb++;
            if (cfg_mid >= 0) g_cfg = cfg_mid;
            if (m_axis_tlast) begin
               got_last = 1;
               break;
            end
         end
      end
      g_rdy = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int nb, firstv, seq_err, stall_err, bp_err, got_last, exp0, cnt3;

      //            rst trg vld dat rdy cfg chk srdy mv ml md  chkd busy pk ms
      vecs[0]  = mk(1, 0, 0,   0, 1, 4, 0,  1, 0, 0,   0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 0, 0,   0, 1, 4, 1,  1, 0, 0,   0, 1, 0, 0, 0);
      vecs[2]  = mk(0, 0, 1, 100, 1, 4, 1,  1, 0, 0,   0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 1, 1, 101, 1, 4, 1,  1, 0, 0,   0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 1, 1, 102, 1, 4, 1,  1, 0, 0,   0, 0, 1, 0, 0);
      vecs[5]  = mk(0, 1, 1, 103, 1, 4, 1,  1, 1, 0, 102, 1, 1, 0, 0);
      vecs[6]  = mk(0, 1, 1, 104, 1, 4, 1,  1, 1, 0, 103, 1, 1, 0, 0);
      vecs[7]  = mk(0, 1, 1, 105, 1, 4, 1,  1, 1, 0, 104, 1, 1, 0, 0);
      vecs[8]  = mk(0, 1, 1, 106, 1, 4, 1,  1, 1, 1, 105, 1, 1, 0, 0);
      vecs[9]  = mk(0, 1, 1, 107, 1, 4, 1,  1, 0, 0,   0, 0, 0, 1, 0);
      vecs[10] = mk(0, 0, 1, 108, 1, 4, 1,  1, 0, 0,   0, 0, 0, 1, 0);
      vecs[11] = mk(0, 1, 1, 109, 1, 1, 1,  1, 0, 0,   0, 0, 0, 1, 0);
      vecs[12] = mk(0, 1, 1, 110, 1, 1, 1,  1, 0, 0,   0, 0, 1, 1, 0);
      vecs[13] = mk(0, 1, 1, 111, 1, 1, 1,  1, 1, 1, 110, 1, 1, 1, 0);
      vecs[14] = mk(0, 0, 1, 112, 1, 1, 1,  1, 0, 0,   0, 0, 0, 2, 0);
      vecs[15] = mk(0, 1, 1, 113, 1, 0, 1,  1, 0, 0,   0, 0, 0, 2, 0);
      vecs[16] = mk(0, 1, 1, 114, 1, 0, 1,  1, 0, 0,   0, 0, 0, 2, 0);
      vecs[17] = mk(0, 0, 1, 115, 1, 0, 1,  1, 0, 0,   0, 0, 0, 2, 0);
      vecs[18] = mk(0, 1, 1, 120, 1, 3, 1,  1, 0, 0,   0, 0, 0, 2, 0);
      vecs[19] = mk(0, 0, 1, 121, 1, 3, 1,  1, 0, 0,   0, 0, 1, 2, 0);
      vecs[20] = mk(0, 1, 1, 122, 1, 3, 1,  1, 1, 0, 121, 1, 1, 2, 0);
      vecs[21] = mk(0, 0, 1, 123, 1, 3, 1,  1, 1, 0, 122, 1, 1, 2, 1);
      vecs[22] = mk(0, 0, 1, 124, 0, 3, 1,  1, 1, 1, 123, 1, 1, 2, 1);
      vecs[23] = mk(0, 1, 1, 125, 1, 3, 1,  1, 1, 1, 123, 1, 1, 2, 1);
      vecs[24] = mk(0, 1, 1, 126, 1, 3, 1,  1, 0, 0,   0, 0, 0, 3, 2);
      vecs[25] = mk(0, 0, 1, 127, 1, 3, 1,  1, 0, 0,   0, 0, 0, 3, 2);
      vecs[26] = mk(0, 1, 1, 130, 1, 2, 1,  1, 0, 0,   0, 0, 0, 3, 2);
      vecs[27] = mk(0, 0, 1, 131, 0, 2, 1,  1, 0, 0,   0, 0, 1, 3, 2);
      vecs[28] = mk(0, 0, 1, 132, 0, 2, 1,  0, 1, 0, 131, 1, 1, 3, 2);
      vecs[29] = mk(0, 0, 1, 132, 1, 2, 1,  1, 1, 0, 131, 1, 1, 3, 2);
      vecs[30] = mk(0, 0, 1, 133, 1, 2, 1,  1, 1, 1, 132, 1, 1, 3, 2);
      vecs[31] = mk(0, 0, 1, 134, 1, 2, 1,  1, 0, 0,   0, 0, 0, 4, 2);

      areset = 1'b1; trg_flag = 1'b0; cfg_data = '0; s_axis_tdata = '0;
      s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge aclk);
         areset        = vecs[i].rst;
         trg_flag      = vecs[i].trg;
         s_axis_tvalid = vecs[i].vld;
         s_axis_tdata  = vecs[i].dat;
         m_axis_tready = vecs[i].rdy;
         cfg_data      = vecs[i].cfg;
         #1;
         if (vecs[i].chk) begin
            check($sformatf("v%0d.s_tready", i), 32'(s_axis_tready), 32'(vecs[i].srdy));
            check($sformatf("v%0d.m_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].mv));
            check($sformatf("v%0d.m_tlast", i),  32'(m_axis_tlast),  32'(vecs[i].ml));
            if (vecs[i].chkd)
               check($sformatf("v%0d.m_tdata", i), 32'(m_axis_tdata), 32'(vecs[i].md));
            check($sformatf("v%0d.busy", i),     32'(sts_busy),      32'(vecs[i].busy));
            check($sformatf("v%0d.packets", i),  sts_packets,        vecs[i].pk);
            check($sformatf("v%0d.missed", i),   32'(sts_missed),    32'(vecs[i].ms));
         end
      end

      // 8-beat frame with the sink toggling ready every cycle.
      pulse(8);
      exp0 = src;
      collect(1'b1, -1, 80, nb, firstv, seq_err, stall_err, bp_err, got_last);
      check("tog.beats", 32'(nb), 32'd8);
      check("tog.first", 32'(firstv), 32'(exp0 & 16'hffff));
      check("tog.seq_err", 32'(seq_err), 32'd0);
      check("tog.stall_err", 32'(stall_err), 32'd0);
      check("tog.bp_err", 32'(bp_err), 32'd0);
      check("tog.tlast", 32'(got_last), 32'd1);
      cycle();
      check("tog.packets", sts_packets, 32'd5);
      check("tog.busy", 32'(sts_busy), 32'd0);

      // cfg_data changes 5 -> 2 during a frame: only the next frame sees it.
      pulse(5);
      exp0 = src;
      collect(1'b0, 2, 40, nb, firstv, seq_err, stall_err, bp_err, got_last);
      check("cfgchg.beats1", 32'(nb), 32'd5);
      check("cfgchg.first1", 32'(firstv), 32'(exp0 & 16'hffff));
      check("cfgchg.seq1", 32'(seq_err), 32'd0);
      cycle();
      check("cfgchg.packets1", sts_packets, 32'd6);
      pulse(int'(g_cfg));
      collect(1'b0, -1, 40, nb, firstv, seq_err, stall_err, bp_err, got_last);
      check("cfgchg.beats2", 32'(nb), 32'd2);
      check("cfgchg.tlast2", 32'(got_last), 32'd1);
      cycle();
      check("cfgchg.packets2", sts_packets, 32'd7);

      // Trigger held high through reset release must not start a frame.
      g_rst = 1'b1; g_trg = 1'b1; g_cfg = 32'd10;
      cycle();
      cycle();
      g_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check($sformatf("trg_hi.busy%0d", k), 32'(sts_busy), 32'd0);
         check($sformatf("trg_hi.tvalid%0d", k), 32'(m_axis_tvalid), 32'd0);
      end
      check("trg_hi.packets", sts_packets, 32'd0);

      // Reset after 3 of 10 beats: frame abandoned, not counted.
      pulse(10);
      cnt3 = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (m_axis_tvalid && g_rdy) cnt3++;
         if (cnt3 == 3) break;
      end
      check("rst_mid.beats_seen", 32'(cnt3), 32'd3);
      check("rst_mid.busy_before", 32'(sts_busy), 32'd1);
      areset = 1'b1;
      cycle();
      check("rst_mid.tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_mid.tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_mid.packets", sts_packets, 32'd0);
      check("rst_mid.missed", 32'(sts_missed), 32'd0);
      check("rst_mid.s_tready", 32'(s_axis_tready), 32'd1);
      check("rst_mid.busy", 32'(sts_busy), 32'd0);
      cycle();
      cycle();
      check("rst_mid.idle_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_mid.idle_busy", 32'(sts_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_frame_gate.md
# axis_frame_gate

Triggered packetizer that sits directly downstream of the pass-through/drain stage on the ADC sample stream. While idle it keeps the upstream stream flowing by accepting and discarding every beat. On a rising edge of a trigger it forwards exactly `cfg_data` consecutive samples through a registered output stage and marks the final one with `m_axis_tlast`. This produces fixed-length, DMA-ready frames.

## Interface
- `AXIS_TDATA_WIDTH`, 16: sample width.
- `CNTR_WIDTH`, 32: width of frame-length config, beat counter and packet counter.
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `cfg_data`  in  CNTR_WIDTH  frame length in beats; latched at trigger.
- `trg_flag`  in  1  trigger level; rising edge starts a frame.
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  input sample.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  registered output sample.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tlast`  out  1  last beat of frame.
- `m_axis_tready`  in  1  output ready.
- `sts_busy`  out  1  high in ACTIVE or DRAIN.
- `sts_packets`  out  CNTR_WIDTH  completed frames, wraps.
- `sts_missed`  out  16  triggers ignored, wraps.

## Operation
- Edge detect: `trg_q` <= `trg_flag`; `trg_edge` = `trg_flag & ~trg_q`. `trg_q` resets to 1, so a trigger already high at reset release is not an edge.
- **IDLE**
  - `s_axis_tready`=1; input beats are discarded.
  - On `trg_edge` with `cfg_data` != 0: latch `len` <= `cfg_data`, clear `cnt`, go to ACTIVE.
  - On `trg_edge` with `cfg_data` == 0: stay in IDLE; no counter changes.
- **ACTIVE**
  - `s_axis_tready` = `~m_axis_tvalid | m_axis_tready`.
  - On an input handshake: load the output register (data, valid=1) and `cnt` <= `cnt`+1.
  - If that beat has `cnt` == `len`-1: set `tlast`=1 on it and go to DRAIN.
- **DRAIN**
  - `s_axis_tready`=1; input is discarded.
  - When the last beat handshakes on the output: clear valid and tlast, increment `sts_packets`, go to IDLE.
- `trg_edge` in ACTIVE or DRAIN is ignored and increments `sts_missed`.
- Output register: if there is no new load and `m_axis_tready` is high, `m_axis_tvalid` <= 0. `tdata` is held while `tvalid` is high and `tready` is low.
- `len` is stable for the whole frame; `cfg_data` changes take effect at the next trigger only.
- `cnt` compare is unsigned, CNTR_WIDTH bits. `len`=1 gives a single beat with tlast.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, `len`=0.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - `sts_packets`=0, `sts_missed`=0, `sts_busy`=0.
  - `s_axis_tready`=1, since the reset state is IDLE.
- Trigger to ACTIVE: edge sampled at cycle T, state is ACTIVE at T+1. The first forwardable input beat is the one handshaken at T+1 or later.
- Latency: input handshake at cycle k gives `m_axis_tvalid`=1 with that data at k+1.
- Throughput: 1 beat/cycle with `m_axis_tready` held high; no bubbles inside a frame.
- Backpressure: `m_axis_tready` low with valid high makes `s_axis_tready` low in the same cycle (combinational). No beat is dropped or duplicated inside a frame.
- Frame end: tlast beat handshake on the output at cycle j gives IDLE and the `sts_packets` increment visible at j+1. `sts_busy` falls at j+1.
- Simultaneous trigger edge and final output handshake in DRAIN: counted as missed; no new frame.
- Reset mid-frame: output valid is dropped immediately with no tlast, and the partial frame is not counted. After that the block is in the IDLE reset state.

## Test plan
- `cfg_data`=4, `m_axis_tready`=1, input ramp 0,1,2,… every cycle, trigger edge → output is 4 consecutive ramp values starting at the first value accepted after the trigger, with tlast on the 4th. `sts_packets`=1, then IDLE discards.
- `cfg_data`=8, `m_axis_tready` toggling 1/0 each cycle → exactly 8 distinct consecutive values in order, no duplicates, and data stable while stalled.
- `cfg_data`=1 → a single beat with tvalid and tlast together, `sts_packets` +1.
- Second trigger edge mid-frame and another in DRAIN → frame unaffected, `sts_missed`=2. `cfg_data`=0 with a trigger → no output, counters unchanged.
- `trg_flag` held high through reset release → no frame starts. Reset asserted after 3 of 10 beats → `m_axis_tvalid`=0 the next cycle, `sts_packets`=0, `s_axis_tready`=1.
- `cfg_data` changed from 5 to 2 during a frame → the current frame is 5 beats and the next triggered frame is 2 beats.
